// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - ctrl encodings for loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW)
//   - FSM state type lsu_state_t and its state constants
//   - latched request struct
//   - lsu_size(): access size in bytes from ctrl[1:0]
//   - BE_W: byte-enable width of one memory word
package lsu_pkg;

    localparam int BE_W = 4;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef logic [2:0] lsu_state_t;
    localparam lsu_state_t S_IDLE   = 3'd0;
    localparam lsu_state_t S_ISSUE0 = 3'd1;
    localparam lsu_state_t S_WAIT0  = 3'd2;
    localparam lsu_state_t S_ISSUE1 = 3'd3;
    localparam lsu_state_t S_WAIT1  = 3'd4;
    localparam lsu_state_t S_RESP   = 3'd5;

    typedef struct packed {
        logic        we;
        logic [2:0]  ctrl;
        logic [31:0] wdata;
    } lsu_req_t;

    // 00 -> byte, 01 -> half, anything else -> word (11 is rejected as illegal)
    function automatic logic [2:0] lsu_size(input logic [1:0] sz);
        case (sz)
            2'b00:   lsu_size = 3'd1;
            2'b01:   lsu_size = 3'd2;
            default: lsu_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for one access.
//   in : we, ctrl, off (addr[1:0]), wdata, rdata0/rdata1 (beat words)
//   out: be0/be1, wd0/wd1 (per-beat enables and steered data), split,
//        illegal (bad ctrl), misalign (H at odd / W at non-zero offset),
//        ld_data (shifted and extended load result)
module lsu_align
    import lsu_pkg::*;
(
    input  logic            we,
    input  logic [2:0]      ctrl,
    input  logic [1:0]      off,
    input  logic [31:0]     wdata,
    input  logic [31:0]     rdata0,
    input  logic [31:0]     rdata1,
    output logic [BE_W-1:0] be0,
    output logic [BE_W-1:0] be1,
    output logic [31:0]     wd0,
    output logic [31:0]     wd1,
    output logic            split,
    output logic            illegal,
    output logic            misalign,
    output logic [31:0]     ld_data
);
    logic [2:0]      size;
    logic [BE_W-1:0] mask;
    logic [7:0]      m64;
    logic [63:0]     w64;
    logic [31:0]     r;

    assign size = lsu_size(ctrl[1:0]);
    assign mask = 4'((5'd1 << size) - 5'd1);
    // Spread over two words so that bytes past the word end land in beat 1
    assign m64  = {4'b0, mask} << off;
    assign w64  = {32'b0, wdata} << {off, 3'b000};
    assign be0  = m64[3:0];
    assign be1  = m64[7:4];
    assign wd0  = w64[31:0];
    assign wd1  = w64[63:32];
    assign split = |m64[7:4];

    assign illegal  = we ? (ctrl >= 3'b011) : ((ctrl[1:0] == 2'b11) || (ctrl == 3'b110));
    assign misalign = ((size == 3'd2) && off[0]) || ((size == 3'd4) && (off != 2'b00));

    assign r = 32'({rdata1, rdata0} >> {off, 3'b000});

    always_comb begin
        ld_data = 32'b0;
        case (ctrl)
            LB:      ld_data = {{24{r[7]}}, r[7:0]};
            LBU:     ld_data = {24'b0, r[7:0]};
            LH:      ld_data = {{16{r[15]}}, r[15:0]};
            LHU:     ld_data = {16'b0, r[15:0]};
            LW:      ld_data = r;
            default: ld_data = 32'b0;
        endcase
    end
endmodule

// File: rtl/lsu_master.sv
// lsu_master: single-outstanding load/store initiator to a word-wide memory.
//   core side : req_valid/req_ready/req_we/req_ctrl/req_addr/req_wdata,
//               rsp_valid/rsp_rdata/rsp_err
//   memory    : mem_req/mem_gnt/mem_we/mem_addr/mem_be/mem_wdata,
//               mem_rvalid/mem_rdata
// Word-crossing accesses become two beats (lower word first). With
// LSU_MISALIGN_TRAP_EN defined, misaligned H/W accesses complete with
// err=1 and no memory traffic instead of being split.
module lsu_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_ctrl,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    lsu_state_t        state;
    lsu_req_t          rq;
    logic [ADDR_W-1:0] rq_addr;
    logic [31:0]       rdata0_q;

    logic              idle;
    logic              a_we;
    logic [2:0]        a_ctrl;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic [31:0]       a_rd0;
    logic [BE_W-1:0]   be0, be1;
    logic [31:0]       wd0, wd1, ld_data;
    logic              split, illegal, misalign, bad;
    logic [ADDR_W-1:0] base;

    // Align on the live request while idle (to issue beat 0 on accept),
    // on the latched copy afterwards.
    assign idle    = (state == S_IDLE);
    assign a_we    = idle ? req_we    : rq.we;
    assign a_ctrl  = idle ? req_ctrl  : rq.ctrl;
    assign a_addr  = idle ? req_addr  : rq_addr;
    assign a_wdata = idle ? req_wdata : rq.wdata;
    // Final beat's word comes straight from the bus; beat 0 from the bus or its capture
    assign a_rd0   = (state == S_WAIT0) ? mem_rdata : rdata0_q;
    assign base    = {a_addr[ADDR_W-1:2], 2'b00};

    lsu_align u_align (
        .we       (a_we),
        .ctrl     (a_ctrl),
        .off      (a_addr[1:0]),
        .wdata    (a_wdata),
        .rdata0   (a_rd0),
        .rdata1   (mem_rdata),
        .be0      (be0),
        .be1      (be1),
        .wd0      (wd0),
        .wd1      (wd1),
        .split    (split),
        .illegal  (illegal),
        .misalign (misalign),
        .ld_data  (ld_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign bad = illegal | misalign;
`else
    assign bad = illegal;
    logic unused_misalign;
    assign unused_misalign = misalign;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rq        <= '0;
            rq_addr   <= '0;
            rdata0_q  <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: if (req_valid) begin
                    rq        <= '{we: req_we, ctrl: req_ctrl, wdata: req_wdata};
                    rq_addr   <= req_addr;
                    req_ready <= 1'b0;
                    if (bad) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        state     <= S_ISSUE0;
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= base;
                        mem_be    <= be0;
                        mem_wdata <= wd0;
                    end
                end
                S_ISSUE0: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    state   <= S_WAIT0;
                end
                S_WAIT0: if (mem_rvalid) begin
                    rdata0_q <= mem_rdata;
                    if (split) begin
                        state     <= S_ISSUE1;
                        mem_req   <= 1'b1;
                        mem_addr  <= base + ADDR_W'(4);
                        mem_be    <= be1;
                        mem_wdata <= wd1;
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= rq.we ? 32'b0 : ld_data;
                    end
                end
                S_ISSUE1: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    state   <= S_WAIT1;
                end
                S_WAIT1: if (mem_rvalid) begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= rq.we ? 32'b0 : ld_data;
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_master.sv
// tb_lsu_master: directed self-checking bench for lsu_master with a
// zero-wait memory model (gnt can be withheld, rvalid can be suppressed
// or injected stray).
module tb_lsu_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_ctrl = 3'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic gnt_en  = 1'b1;
    logic hold_rv = 1'b0;
    logic stray   = 1'b0;
    logic rv_q    = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    int          beat_cnt = 0;
    logic [31:0] b_addr [0:31];
    logic [3:0]  b_be   [0:31];
    logic [31:0] b_wd   [0:31];
    logic        b_we   [0:31];

    always #5 clk = ~clk;

    lsu_master #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        case (a)
            32'h0FC: memword = 32'hAABBCCDD;
            32'h100: memword = 32'h11223344;
            32'h200: memword = 32'h80FF1234;
            default: memword = 32'h0;
        endcase
    endfunction

    assign mem_gnt    = mem_req & gnt_en;
    assign mem_rvalid = rv_q | stray;

    always @(posedge clk) begin
        rv_q      <= mem_req && mem_gnt && !hold_rv;
        mem_rdata <= memword(mem_addr);
        if (mem_req && mem_gnt) begin
            b_addr[beat_cnt[4:0]] <= mem_addr;
            b_be[beat_cnt[4:0]]   <= mem_be;
            b_wd[beat_cnt[4:0]]   <= mem_wdata;
            b_we[beat_cnt[4:0]]   <= mem_we;
            beat_cnt              <= beat_cnt + 1;
        end
    end

    task automatic run_req(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd,
                           output logic er, output int nb, output int b0);
        @(negedge clk);
        req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        b0 = beat_cnt;
        lat = 0; rd = 'x; er = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = i; rd = rsp_rdata; er = rsp_err;
                break;
            end
        end
        nb = beat_cnt - b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({req_ready, rsp_valid, rsp_err, mem_req, mem_we} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctl got=%b exp=10000", {req_ready, rsp_valid, rsp_err, mem_req, mem_we});
        end
        n_tests++;
        if ({rsp_rdata, mem_addr, mem_wdata, mem_be} !== '0) begin
            n_fail++;
            $display("FAIL reset_data rdata=%h addr=%h wdata=%h be=%b exp all 0",
                     rsp_rdata, mem_addr, mem_wdata, mem_be);
        end
        rst = 1'b0;
    endtask

    task automatic test_sw_aligned();
        int lat, nb, b0; logic [31:0] rd; logic er;
        run_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, lat, rd, er, nb, b0);
        n_tests++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'h0 || nb !== 1) begin
            n_fail++;
            $display("FAIL sw_rsp lat=%0d err=%b rdata=%h beats=%0d exp 3/0/0/1", lat, er, rd, nb);
        end
        n_tests++;
        if (b_addr[b0] !== 32'h100 || b_be[b0] !== 4'b1111 || b_wd[b0] !== 32'hDEADBEEF || b_we[b0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_beat addr=%h be=%b wd=%h we=%b exp 100/1111/deadbeef/1",
                     b_addr[b0], b_be[b0], b_wd[b0], b_we[b0]);
        end
    endtask

    task automatic test_load_ext();
        int lat, nb, b0; logic [31:0] rd; logic er;
        logic [2:0]  ctl [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adr [4] = '{32'h203, 32'h203, 32'h202, 32'h202};
        logic [3:0]  ebe [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, ctl[i], adr[i], 32'h0, lat, rd, er, nb, b0);
            n_tests++;
            if (rd !== exp[i] || er !== 1'b0 || lat !== 3 || nb !== 1 ||
                b_be[b0] !== ebe[i] || b_addr[b0] !== 32'h200 || b_we[b0] !== 1'b0) begin
                n_fail++;
                $display("FAIL load_ext[%0d] rdata=%h err=%b lat=%0d beats=%0d be=%b addr=%h exp %h/0/3/1/%b/200",
                         i, rd, er, lat, nb, b_be[b0], b_addr[b0], exp[i], ebe[i]);
            end
        end
    endtask

    task automatic test_split_lw();
        int lat, nb, b0; logic [31:0] rd; logic er;
        run_req(1'b0, 3'b010, 32'h0FE, 32'h0, lat, rd, er, nb, b0);
`ifdef LSU_MISALIGN_TRAP_EN
        n_tests++;
        if (er !== 1'b1 || nb !== 0 || lat !== 1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL split_lw_trap err=%b beats=%0d lat=%0d rdata=%h exp 1/0/1/0", er, nb, lat, rd);
        end
`else
        n_tests++;
        if (rd !== 32'h3344AABB || er !== 1'b0 || lat !== 5 || nb !== 2) begin
            n_fail++;
            $display("FAIL split_lw_rsp rdata=%h err=%b lat=%0d beats=%0d exp 3344aabb/0/5/2", rd, er, lat, nb);
        end
        n_tests++;
        if (b_addr[b0] !== 32'h0FC || b_be[b0] !== 4'b1100 ||
            b_addr[b0+1] !== 32'h100 || b_be[b0+1] !== 4'b0011) begin
            n_fail++;
            $display("FAIL split_lw_beats a0=%h be0=%b a1=%h be1=%b exp 0fc/1100/100/0011",
                     b_addr[b0], b_be[b0], b_addr[b0+1], b_be[b0+1]);
        end
`endif
    endtask

    task automatic test_split_sh();
        int lat, nb, b0; logic [31:0] rd; logic er;
        run_req(1'b1, 3'b001, 32'h13, 32'h0000ABCD, lat, rd, er, nb, b0);
`ifdef LSU_MISALIGN_TRAP_EN
        n_tests++;
        if (er !== 1'b1 || nb !== 0 || lat !== 1) begin
            n_fail++;
            $display("FAIL split_sh_trap err=%b beats=%0d lat=%0d exp 1/0/1", er, nb, lat);
        end
`else
        n_tests++;
        if (er !== 1'b0 || nb !== 2 || lat !== 5 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL split_sh_rsp err=%b beats=%0d lat=%0d rdata=%h exp 0/2/5/0", er, nb, lat, rd);
        end
        n_tests++;
        if (b_addr[b0] !== 32'h10 || b_be[b0] !== 4'b1000 || b_wd[b0] !== 32'hCD000000 ||
            b_addr[b0+1] !== 32'h14 || b_be[b0+1] !== 4'b0001 || b_wd[b0+1] !== 32'h000000AB) begin
            n_fail++;
            $display("FAIL split_sh_beats a0=%h be0=%b w0=%h a1=%h be1=%b w1=%h exp 10/1000/cd000000/14/0001/000000ab",
                     b_addr[b0], b_be[b0], b_wd[b0], b_addr[b0+1], b_be[b0+1], b_wd[b0+1]);
        end
`endif
    endtask

    task automatic test_stall();
        logic [31:0] a0, w0; logic [3:0] be; logic got; int b0;
        gnt_en = 1'b0;
        @(negedge clk);
        req_we = 1'b0; req_ctrl = 3'b010; req_addr = 32'h100; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        b0 = beat_cnt;
        @(negedge clk);
        a0 = mem_addr; be = mem_be; w0 = mem_wdata;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1111 ||
                mem_addr !== a0 || mem_be !== be || mem_wdata !== w0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] req=%b addr=%h be=%b exp 1/100/1111 held", i, mem_req, mem_addr, mem_be);
            end
            if (i < 2) @(negedge clk);
        end
        gnt_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin got = 1'b1; break; end
        end
        n_tests++;
        if (got !== 1'b1 || rsp_rdata !== 32'h11223344 || rsp_err !== 1'b0 || beat_cnt - b0 !== 1) begin
            n_fail++;
            $display("FAIL stall_done got=%b rdata=%h err=%b beats=%0d exp 1/11223344/0/1",
                     got, rsp_rdata, rsp_err, beat_cnt - b0);
        end
    endtask

    task automatic test_illegal();
        int lat, nb, b0; logic [31:0] rd; logic er;
        run_req(1'b0, 3'b011, 32'h100, 32'h0, lat, rd, er, nb, b0);
        n_tests++;
        if (er !== 1'b1 || rd !== 32'h0 || nb !== 0 || lat !== 1) begin
            n_fail++;
            $display("FAIL illegal_ld err=%b rdata=%h beats=%0d lat=%0d exp 1/0/0/1", er, rd, nb, lat);
        end
        run_req(1'b1, 3'b100, 32'h100, 32'h55, lat, rd, er, nb, b0);
        n_tests++;
        if (er !== 1'b1 || nb !== 0 || lat !== 1) begin
            n_fail++;
            $display("FAIL illegal_st err=%b beats=%0d lat=%0d exp 1/0/1", er, nb, lat);
        end
    endtask

    task automatic test_rst_midflight();
        logic seen;
        // reset while waiting for read data
        hold_rv = 1'b1;
        @(negedge clk);
        req_we = 1'b0; req_ctrl = 3'b010; req_addr = 32'h100; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1 || mem_req !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wait0 ready=%b mem_req=%b rsp_valid=%b exp 1/0/0", req_ready, mem_req, rsp_valid);
        end
        rst = 1'b0; hold_rv = 1'b0; stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b0 || mem_req !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stray_rvalid activity=%b exp 0", seen);
        end
        // reset while a request is still waiting for grant
        gnt_en = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_issue0 mem_req=%b ready=%b exp 0/1", mem_req, req_ready);
        end
        rst = 1'b0; gnt_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int lat, nb, b0; logic [31:0] rd; logic er;
        run_req(1'b0, 3'b010, 32'h0FC, 32'h0, lat, rd, er, nb, b0);
        n_tests++;
        if (rd !== 32'hAABBCCDD || er !== 1'b0 || lat !== 3 || nb !== 1) begin
            n_fail++;
            $display("FAIL b2b_lw rdata=%h err=%b lat=%0d beats=%0d exp aabbccdd/0/3/1", rd, er, lat, nb);
        end
        run_req(1'b1, 3'b000, 32'h101, 32'h000000A5, lat, rd, er, nb, b0);
        n_tests++;
        if (b_be[b0] !== 4'b0010 || b_wd[b0] !== 32'h0000A500 || b_addr[b0] !== 32'h100 || lat !== 3) begin
            n_fail++;
            $display("FAIL b2b_sb be=%b wd=%h addr=%h lat=%0d exp 0010/0000a500/100/3",
                     b_be[b0], b_wd[b0], b_addr[b0], lat);
        end
    endtask

    initial begin
        test_reset();
        test_sw_aligned();
        test_load_ext();
        test_split_lw();
        test_split_sh();
        test_stall();
        test_illegal();
        test_rst_midflight();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lsu_master.md
Name: lsu_master

Overview:
- Load/store initiator for the core's data-memory path. It accepts one load or store at a time from the execute stage.
- Issues word-granular, byte-enabled transactions to a word-wide data memory over a req/gnt/rvalid handshake.
- Performs byte-lane steering, sign/zero extension and splitting of word-crossing accesses.
- Sits between the core datapath and the data memory / bus port.

Parameters:
- ADDR_W, 32, byte address width on both sides; mem_addr[1:0] always 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  core request valid
- req_ready  out  1  high only in IDLE; transfer when valid&&ready
- req_we  in  1  1=store, 0=load
- req_ctrl  in  3  load: LB=000 LH=001 LW=010 LBU=100 LHU=101; store: SB=000 SH=001 SW=010
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse (loads and stores)
- rsp_rdata  out  32  extended load data; 0 for stores/errors
- rsp_err  out  1  qualified by rsp_valid; illegal ctrl (or misaligned when trapping)
- mem_req  out  1  memory request, held until mem_gnt
- mem_gnt  in  1  request accepted this cycle
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word-aligned address
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-steered write data
- mem_rvalid  in  1  one per granted access; read data valid, or write ack
- mem_rdata  in  32  read word

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset values: FSM=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_req=0; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0. All outputs are registered.
- States:
  - IDLE: on accept, latch the request. Legal → ISSUE0; illegal → RESP with err.
  - ISSUE0: mem_req=1 until mem_gnt, then → WAIT0.
  - WAIT0: on mem_rvalid, capture beat 0, then → ISSUE1 if split, else RESP.
  - ISSUE1: mem_req=1 until mem_gnt, then → WAIT1.
  - WAIT1: on mem_rvalid, capture beat 1, then → RESP.
  - RESP: rsp_valid=1 for one cycle, then → IDLE.
- Sizes: byte size(B)=1, H=2, W=4.
- Illegal ctrl:
  - load: 011, 110, 111
  - store: any value ≥011
  - Response: err=1, no memory traffic.
- Lane math:
  - off = addr[1:0]; mask = (1<<size)-1; wide mask m64 = mask<<off; wide data w64 = {32'b0,wdata}<<(8*off).
  - Beat 0: addr&~3, be=m64[3:0], wdata=w64[31:0].
  - Beat 1 (only when m64[7:4]≠0): addr&~3 + 4 (wraps modulo 2^ADDR_W), be=m64[7:4], wdata=w64[63:32].
- Load assembly: r = ({rdata1,rdata0} >> 8*off), then extend by ctrl:
  - LB: sign-extend r[7]
  - LBU: zero-extend byte
  - LH: sign-extend r[15]
  - LHU: zero-extend halfword
  - LW: r[31:0]
- Latency (zero-wait memory, gnt same cycle as req, rvalid next cycle):
  - Accept at T: mem_req T+1, rvalid T+2, rsp_valid T+3.
  - Split access: rsp_valid T+5.
- Mid-transaction rules:
  - mem_addr/be/we/wdata are stable while mem_req=1 and not granted.
  - mem_rvalid outside WAIT0/WAIT1 is ignored.
  - req_valid outside IDLE is ignored (req_ready=0).
  - rst in any state → IDLE next cycle; mem_req drops immediately; a late rvalid after reset is ignored.
- Only one outstanding access; the next beat issues only after rvalid.

Optional Feature:
- LSU_MISALIGN_TRAP_EN
  - Defined: any access with (H and off[0]) or (W and off≠0) completes with err=1, no memory traffic; ISSUE1/WAIT1 are never entered.
  - Undefined: misaligned accesses are split as above; aligned behaviour is identical in both builds.

Decomposition:
- Package lsu_pkg:
  - ctrl encodings (LB/LH/LW/LBU/LHU/SB/SH/SW)
  - state enum lsu_state_t
  - size-decode function
  - be-mask width constant
- One natural sub-module: lsu_align. Combinational beat generation for both beats: be, wdata, split flag, illegal flag, plus load extension.

Test Plan:
- Aligned SW: addr=0x100, wdata=0xDEADBEEF → one beat, mem_addr=0x100, be=1111, wdata=0xDEADBEEF; rsp_valid at T+3, err=0.
- LB sign: addr=0x203, mem word 0x80FF_1234 → be=1000, rsp_rdata=0xFFFFFF80; LBU same access → 0x00000080.
- Split LW: addr=0x0FE, words 0x0FC=0xAABBCCDD, 0x100=0x11223344:
  - beat0 be=1100; beat1 mem_addr=0x100, be=0011
  - rsp_rdata=0x3344AABB; rsp_valid at T+5
  - with trap macro: err=1, no mem_req
- SH at off=3: wdata=0x0000ABCD, addr=0x13 → beat0 addr=0x10, be=1000, wdata=0xCD000000; beat1 addr=0x14, be=0001, wdata=0x000000AB.
- Stalled grant: mem_gnt low for 3 cycles → mem_req and payload held constant; single beat completes after gnt.
- Illegal ctrl load 011, then rst asserted in WAIT0 → first: err=1, rdata=0, no mem_req; second: IDLE next cycle, req_ready=1, a stray rvalid produces no rsp_valid.
